// File: rtl/chess_clock_pkg.sv
// Shared game_play types: the screen FSM state seen by the clock engine.
package chess_clock_pkg;

  typedef enum logic [1:0] {
    SETUP_SCREEN  = 2'd0,
    CHESS_SCREEN  = 2'd1,
    RESULT_SCREEN = 2'd2,
    MENU_SCREEN   = 2'd3
  } screen_state_t;

endpackage

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock engine: centisecond countdown for the side to move,
// per-move increment with saturation, and sticky out-of-time flags.
module chess_clock_ctrl
  import chess_clock_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INC_CS      = 0,
  parameter int MAX_CS      = 180000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  screen_state_t state,
  input  logic [1:0]    mode_sel,
  input  logic          move_done,
  input  logic          pause,
  output logic [17:0]   white_cs,
  output logic [17:0]   black_cs,
  output logic [17:0]   active_cs,
  output logic          turn,
  output logic          running,
  output logic          tick_100hz,
  output logic          flag_white,
  output logic          flag_black,
  output logic          game_over
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] FLAGGED = 2'd3;

  localparam int TICK_DIV = CLK_FREQ_HZ / 100;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [18:0]   INC_19   = 19'(INC_CS);
  localparam logic [18:0]   MAX_19   = 19'(MAX_CS);
  localparam logic [17:0]   MAX_18   = 18'(MAX_CS);

  logic [1:0]    fsm;
  logic [PW-1:0] prescale;
  logic          in_chess;
  logic          wrap;

  // One extra bit so the increment cannot wrap before the ceiling compare.
  function automatic logic [17:0] add_sat(input logic [17:0] t);
    logic [18:0] sum;
    sum = {1'b0, t} + INC_19;
    return (sum > MAX_19) ? MAX_18 : sum[17:0];
  endfunction

  function automatic logic [17:0] initial_cs(input logic [1:0] sel);
    case (sel)
      2'd0:    return 18'd6000;
      2'd1:    return 18'd18000;
      2'd2:    return 18'd60000;
      default: return 18'd180000;
    endcase
  endfunction

  assign in_chess = (state == CHESS_SCREEN);
  assign wrap     = (prescale == PRE_LAST);

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch reads the pre-edge values; mixing in blocking writes here would
  // make the result depend on statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm        <= IDLE;
      prescale   <= '0;
      white_cs   <= '0;
      black_cs   <= '0;
      turn       <= 1'b0;
      tick_100hz <= 1'b0;
      flag_white <= 1'b0;
      flag_black <= 1'b0;
    end else begin
      tick_100hz <= 1'b0;
      if (!in_chess) fsm <= IDLE;

      if (fsm == IDLE) begin
        prescale <= '0;
        if (state == SETUP_SCREEN) begin
          white_cs   <= initial_cs(mode_sel);
          black_cs   <= initial_cs(mode_sel);
          turn       <= 1'b0;
          flag_white <= 1'b0;
          flag_black <= 1'b0;
        end else if (in_chess) begin
          fsm <= RUN;
        end
      end else if (fsm == PAUSED) begin
        if (in_chess && !pause) fsm <= RUN;
      end else if (fsm == RUN && in_chess) begin
        if (pause) begin
          fsm <= PAUSED;
        end else begin
          prescale   <= wrap ? '0 : prescale + PW'(1);
          tick_100hz <= wrap;
          // A move on the tick edge wins: the decrement is dropped, so no flag.
          if (move_done) begin
            if (!turn) white_cs <= add_sat(white_cs);
            else       black_cs <= add_sat(black_cs);
            turn <= ~turn;
          end else if (wrap) begin
            if (!turn) begin
              if (white_cs != '0) white_cs <= white_cs - 18'd1;
              if (white_cs == 18'd1) begin
                flag_white <= 1'b1;
                fsm        <= FLAGGED;
              end
            end else begin
              if (black_cs != '0) black_cs <= black_cs - 18'd1;
              if (black_cs == 18'd1) begin
                flag_black <= 1'b1;
                fsm        <= FLAGGED;
              end
            end
          end
        end
      end
    end
  end

  assign active_cs = turn ? black_cs : white_cs;
  assign running   = (fsm == RUN);
  assign game_over = flag_white | flag_black;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Directed bench for chess_clock_ctrl at CLK_FREQ_HZ=1000 (10-clock tick), INC_CS=200.
module tb_chess_clock_ctrl;
  import chess_clock_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n;
  screen_state_t state;
  logic [1:0]    mode_sel;
  logic          move_done;
  logic          pause;
  logic [17:0]   white_cs;
  logic [17:0]   black_cs;
  logic [17:0]   active_cs;
  logic          turn;
  logic          running;
  logic          tick_100hz;
  logic          flag_white;
  logic          flag_black;
  logic          game_over;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;

  chess_clock_ctrl #(
    .CLK_FREQ_HZ(1000),
    .INC_CS     (200),
    .MAX_CS     (180000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .state     (state),
    .mode_sel  (mode_sel),
    .move_done (move_done),
    .pause     (pause),
    .white_cs  (white_cs),
    .black_cs  (black_cs),
    .active_cs (active_cs),
    .turn      (turn),
    .running   (running),
    .tick_100hz(tick_100hz),
    .flag_white(flag_white),
    .flag_black(flag_black),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled on falling edges.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (tick_100hz) tick_cnt++;
    end
  endtask

  task automatic pulse_move();
    move_done = 1'b1;
    cyc(1);
    move_done = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    state     = SETUP_SCREEN;
    mode_sel  = 2'd1;
    move_done = 1'b0;
    pause     = 1'b0;
    #1;
    check("rst_white", 32'(white_cs), 0);
    check("rst_black", 32'(black_cs), 0);
    check("rst_outs", {turn, running, tick_100hz, flag_white, flag_black, game_over}, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    check("setup_white", 32'(white_cs), 18000);
    check("setup_black", 32'(black_cs), 18000);

    // 105 clocks of play: ticks on edges 11,21..101
    state    = CHESS_SCREEN;
    tick_cnt = 0;
    cyc(105);
    check("run_white", 32'(white_cs), 17990);
    check("run_black", 32'(black_cs), 18000);
    check("run_turn", 32'(turn), 0);
    check("run_ticks", 32'(tick_cnt), 10);
    check("run_running", 32'(running), 1);

    // prescaler sits at 4; pause 50 clocks, then 6 edges (1 resume + 5 counts) to the tick
    pause    = 1'b1;
    tick_cnt = 0;
    cyc(50);
    check("pause_ticks", 32'(tick_cnt), 0);
    check("pause_white", 32'(white_cs), 17990);
    check("pause_running", 32'(running), 0);
    pause = 1'b0;
    cyc(6);
    check("resume_early", 32'(white_cs), 17990);
    cyc(1);
    check("resume_tick", 32'(white_cs), 17989);

    // leaving the chess screen holds values
    state = RESULT_SCREEN;
    cyc(1);
    check("idle_running", 32'(running), 0);
    tick_cnt = 0;
    cyc(20);
    check("idle_white", 32'(white_cs), 17989);
    check("idle_black", 32'(black_cs), 18000);
    check("idle_ticks", 32'(tick_cnt), 0);

    // async reset mid-RUN
    state = CHESS_SCREEN;
    cyc(3);
    check("rerun_running", 32'(running), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_white", 32'(white_cs), 0);
    check("arst_outs", {turn, running, flag_white, flag_black, game_over}, 0);
    state = MENU_SCREEN;
    @(negedge clk);
    reset_n  = 1'b1;
    tick_cnt = 0;
    cyc(30);
    check("arst_no_tick", 32'(tick_cnt), 0);
    check("arst_hold", 32'(black_cs), 0);

    // mode_sel changes in setup apply the next cycle; increment saturates
    state    = SETUP_SCREEN;
    mode_sel = 2'd3;
    cyc(1);
    check("mode3", 32'(white_cs), 180000);
    mode_sel = 2'd2;
    cyc(1);
    check("mode2", 32'(black_cs), 60000);
    mode_sel = 2'd3;
    cyc(1);
    state = CHESS_SCREEN;
    cyc(1);
    pulse_move();
    check("sat_white_cap", 32'(white_cs), 180000);
    check("sat_turn", 32'(turn), 1);
    cyc(9);
    check("black_first", 32'(black_cs), 179999);
    check("black_white_hold", 32'(white_cs), 180000);
    cyc(990);
    check("black_179900", 32'(black_cs), 179900);
    pulse_move();
    check("sat_black", 32'(black_cs), 180000);
    check("sat_turn_back", 32'(turn), 0);
    check("sat_active", 32'(active_cs), 180000);

    // increment, then long white countdown to the flag
    state    = SETUP_SCREEN;
    mode_sel = 2'd0;
    cyc(2);
    check("mode0", 32'(white_cs), 6000);
    state = CHESS_SCREEN;
    cyc(10001);
    check("white_5000", 32'(white_cs), 5000);
    pulse_move();
    check("inc_white", 32'(white_cs), 5200);
    check("inc_turn", 32'(turn), 1);
    check("inc_active", 32'(active_cs), 6000);
    cyc(9);
    check("blk_tick", 32'(black_cs), 5999);
    check("blk_tick_white", 32'(white_cs), 5200);
    pulse_move();
    check("blk_inc", 32'(black_cs), 6199);
    cyc(51989);
    check("white_1", 32'(white_cs), 1);
    cyc(9);
    pulse_move();
    check("coinc_white", 32'(white_cs), 201);
    check("coinc_flag", 32'(flag_white), 0);
    check("coinc_turn", 32'(turn), 1);
    pulse_move();
    check("blk_inc2", 32'(black_cs), 6399);
    cyc(1999);
    check("white_1_again", 32'(white_cs), 1);
    cyc(10);
    check("flag_white_cs", 32'(white_cs), 0);
    check("flag_white", 32'(flag_white), 1);
    check("flag_black", 32'(flag_black), 0);
    check("flag_game_over", 32'(game_over), 1);
    check("flag_running", 32'(running), 0);
    pulse_move();
    pause = 1'b1;
    cyc(15);
    pause = 1'b0;
    cyc(15);
    check("flag_hold_white", 32'(white_cs), 0);
    check("flag_hold_black", 32'(black_cs), 6399);
    check("flag_hold_turn", 32'(turn), 0);
    check("flag_hold_go", 32'(game_over), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chess_clock_ctrl.md
Name: chess_clock_ctrl

Overview:
- Two-player chess clock engine in game_play. Holds white and black remaining time in centiseconds, counts down the side to move, and switches turns on each completed move.
- Applies a per-move increment and raises flag/game-over when a side runs out.
- Sits upstream of the per-side hex display stage and the game-over logic. It feeds them raw 18-bit centisecond values and status flags.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency. Tick period = CLK_FREQ_HZ/100 clocks.
- INC_CS, 0, increment in centiseconds added to the mover's time on each move_done.
- MAX_CS, 180000, saturation ceiling for either side's time (30 min).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- state  in  screen_state_t  screen FSM state (SETUP_SCREEN, CHESS_SCREEN, others)
- mode_sel  in  2  initial time select: 0=6000, 1=18000, 2=60000, 3=180000 cs
- move_done  in  1  single-cycle pulse: side to move completed a legal move
- pause  in  1  level; high freezes the clock
- white_cs  out  18  white remaining centiseconds
- black_cs  out  18  black remaining centiseconds
- active_cs  out  18  remaining time of side to move (white_cs when turn=0, else black_cs)
- turn  out  1  0=white to move, 1=black to move
- running  out  1  high when FSM is in RUN
- tick_100hz  out  1  one-cycle pulse on each counted centisecond
- flag_white  out  1  white ran out of time (sticky)
- flag_black  out  1  black ran out of time (sticky)
- game_over  out  1  flag_white | flag_black

Behaviour:
- Reset (async): FSM=IDLE, white_cs=black_cs=0, turn=0, prescaler=0, flags=0. All outputs are 0.
- FSM states: IDLE, RUN, PAUSED, FLAGGED. Transitions:
  - Any state with state!=CHESS_SCREEN -> IDLE on the next clk.
  - IDLE with state==CHESS_SCREEN -> RUN.
  - RUN with pause=1 -> PAUSED.
  - PAUSED with pause=0 -> RUN.
  - RUN when a decrement produces 0 -> FLAGGED.
  - FLAGGED holds until state leaves CHESS_SCREEN.
- IDLE:
  - When state==SETUP_SCREEN, every cycle load white_cs=black_cs=initial(mode_sel), clear turn, flags and prescaler.
  - Any other non-chess screen holds all values.
  - mode_sel changes during SETUP_SCREEN take effect the next cycle.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ/100-1, only in RUN. Held in PAUSED/FLAGGED, cleared in IDLE.
  - Wrap in RUN generates tick_100hz, registered and aligned with the decrement.
- Tick in RUN (no move_done): active side time -= 1.
  - Transition 1->0 sets that side's flag. FSM -> FLAGGED on the same edge.
  - Time never goes below 0.
- move_done in RUN:
  - Mover's time = min(time + INC_CS, MAX_CS). turn toggles on the same edge.
  - The new active side's countdown continues from the current prescaler value; prescaler is not reset.
- move_done coincident with tick: the tick's decrement is dropped, the increment applies, and the turn toggles. No flag is raised.
- move_done in IDLE, PAUSED or FLAGGED is ignored. pause in FLAGGED is ignored.
- Entering RUN from IDLE does not reload; values loaded in SETUP are used as-is.
- active_cs, running and game_over are combinational from registered state.
- Width rule: all time arithmetic is 18-bit unsigned. Saturation is computed in 19 bits and compared against MAX_CS.

Test Plan:
- Use CLK_FREQ_HZ=1000 (10-clk tick).
- Async reset mid-RUN -> all outputs 0 immediately, FSM IDLE, no tick_100hz after release until re-entering CHESS_SCREEN.
- SETUP_SCREEN with mode_sel=1, then CHESS_SCREEN for 105 clks -> white_cs=17990, black_cs=18000, turn=0, 10 ticks.
- INC_CS=200, white at 5000, move_done pulse -> white_cs=5200, turn=1. Next tick decrements black only. Black at 179900 on its move -> saturates to 180000.
- white_cs=1, tick with no move_done -> white_cs=0, flag_white=1, game_over=1, running=0. Further move_done/ticks leave both times unchanged.
- white_cs=1, move_done on the exact tick cycle with INC_CS=0 -> white_cs=1, no flag, turn=1.
- pause high for 50 clks mid-count -> no ticks and times frozen. On pause low, the first tick arrives after the remaining prescaler count, not a full period. A state change to a non-chess screen -> IDLE, values held.
